fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of the synchronous FIFO between NUM_REQ producers. Grants bounded bursts, applies FIFO full/almost-full backpressure, and drives a registered wr_en/data_in pair straight into the FIFO. It sits between the producer blocks and the FIFO's write-side interface.

---
 rtl/fifo_wr_arbiter_pkg.sv | 44 ++++
 rtl/fifo_wr_arbiter_picker.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);
    localparam int MAX_REQ     = 8;
    localparam int MAX_ID_W    = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Rotate so ptr sits at bit 0, find the first set bit, then rotate the index back.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        logic [MAX_REQ-1:0] rot;
        pick_t              res;
        int                 off;
        rot = '0;
        res = '0;
        off = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                rot[i] = req[MAX_ID_W'((int'(ptr) + i) % n)];
            end
        end
        for (int i = 0; i < MAX_REQ; i++) begin
            if (!res.vld && rot[i]) begin
                res.vld = 1'b1;
                off     = i;
            end
        end
        res.idx = MAX_ID_W'((int'(ptr) + off) % n);
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin winner select: rotate, find-first-set, unrotate.
// Zero latency; no flow control of its own.
module rr_priority_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr), NUM_REQ);
        valid = pick.vld;
        idx   = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a FIFO write port; one-cycle registered write path.
// gnt is withheld whenever the FIFO cannot take a beat, including the in-flight write.
// Optional per-requester beat and stall counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BURST  = 4,
    localparam int OWN_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [OWN_W-1:0]              owner_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         beat_count,
    output logic [15:0]                   stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e            state, state_n;
    logic [OWN_W-1:0]      rr_ptr, rr_ptr_n;
    logic [OWN_W-1:0]      owner_n;
    logic [OWN_W-1:0]      win_id;
    logic [OWN_W-1:0]      acc_id;
    logic [CNT_W-1:0]      beat_cnt, beat_n;
    logic                  win_vld;
    logic                  can_accept;
    logic                  acc;
    logic [DATA_WIDTH-1:0] acc_data;

    function automatic logic [OWN_W-1:0] next_ptr(input logic [OWN_W-1:0] id);
        return (id == OWN_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (win_vld),
        .idx   (win_id)
    );

    // A write already registered toward an almost-full FIFO consumes the last slot.
    assign can_accept = !fifo_full && !(fifo_wr_en && fifo_almostfull);
    assign busy       = (state == BURST);

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        beat_n   = beat_cnt;
        owner_n  = owner_id;
        gnt      = '0;
        acc      = 1'b0;
        acc_id   = owner_id;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner_n = win_id;
                        if (can_accept) begin
                            gnt[win_id] = 1'b1;
                            acc         = 1'b1;
                            acc_id      = win_id;
                            if (MAX_BURST == 1) begin
                                rr_ptr_n = next_ptr(win_id);
                            end else begin
                                beat_n  = CNT_W'(1);
                                state_n = BURST;
                            end
                        end else begin
                            beat_n  = '0;
                            state_n = BURST;
                        end
                    end
                end
                BURST: begin
                    if (!req[owner_id]) begin
                        state_n  = IDLE;
                        rr_ptr_n = next_ptr(owner_id);
                        beat_n   = '0;
                    end else if (can_accept) begin
                        gnt[owner_id] = 1'b1;
                        acc           = 1'b1;
                        if (beat_cnt + 1'b1 == CNT_W'(MAX_BURST)) begin
                            state_n  = IDLE;
                            rr_ptr_n = next_ptr(owner_id);
                            beat_n   = '0;
                        end else begin
                            beat_n = beat_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_id == OWN_W'(i)) begin
                acc_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            beat_cnt     <= '0;
            owner_id     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            beat_cnt   <= beat_n;
            owner_id   <= owner_n;
            fifo_wr_en <= acc;
            if (acc) begin
                fifo_data_in <= acc_data;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count   <= '0;
            stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc && acc_id == OWN_W'(i) && beat_count[i*16 +: 16] != 16'hFFFF) begin
                    beat_count[i*16 +: 16] <= beat_count[i*16 +: 16] + 16'd1;
                end
            end
            if (|req && !can_accept && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected grants per cycle, accepted data scoreboarded
// against the registered FIFO write one cycle later.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  gnt;
    logic           fifo_full = 1'b0;
    logic           fifo_almostfull = 1'b0;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_data_in;
    logic [1:0]     owner_id;
    logic           busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0] beat_count;
    logic [15:0]      stall_cycles;
`endif

    logic [DW-1:0]  dat [NR];
    logic [DW-1:0]  exp_q [$];
    logic [DW-1:0]  last_data = '0;
    int             n_checks = 0;
    int             n_fail = 0;
    int             bump_idx = -1;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .owner_id        (owner_id),
        .busy            (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_count      (beat_count),
        .stall_cycles    (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs just after, record the expected beat.
    task automatic cyc(input logic rs, input logic [3:0] r, input logic af, input logic f,
                       input logic [3:0] eg, input logic eb);
        @(negedge clk);
        if (bump_idx >= 0) begin
            dat[bump_idx] = dat[bump_idx] + 16'd1;
            bump_idx = -1;
        end
        rst = rs;
        req = r;
        fifo_almostfull = af;
        fifo_full = f;
        #1;
        chk("wr_en", 32'(fifo_wr_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) last_data = exp_q.pop_front();
        chk("data_in", 32'(fifo_data_in), 32'(last_data));
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(eb));
        for (int i = 0; i < NR; i++) begin
            if (eg[i]) begin
                exp_q.push_back(dat[i]);
                bump_idx = i;
            end
        end
        if (rs) begin
            exp_q.delete();
            last_data = '0;
        end
    endtask

    initial begin
        dat[0] = 16'h00A1;
        dat[1] = 16'h0B01;
        dat[2] = 16'h0C01;
        dat[3] = 16'h0D01;

        // reset: no grants even with requests pending, then quiet idle
        cyc(1, 4'b1111, 0, 0, 4'b0000, 0);
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        repeat (5) cyc(0, 4'b0000, 0, 0, 4'b0000, 0);

        // single requester: 4-beat burst, then immediately re-granted from IDLE
        for (int k = 0; k < 6; k++) cyc(0, 4'b0001, 0, 0, 4'b0001, (k != 0 && k != 4));
        cyc(0, 4'b0000, 0, 0, 4'b0000, 1);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);
        chk("owner_solo", 32'(owner_id), 32'd0);

        // all requesting: bursts rotate 0,1,2,3 and wrap back to 0
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < MB; k++)
                cyc(0, 4'b1111, 0, 0, 4'(1 << (b % NR)), (k != 0));
        cyc(1, 4'b1111, 0, 0, 4'b0000, 0);

        // backpressure on owner 2: almost-full with a write in flight, then full for 3 cycles
        cyc(0, 4'b0100, 0, 0, 4'b0100, 0);
        cyc(0, 4'b0100, 1, 0, 4'b0000, 1);
        chk("owner_stall", 32'(owner_id), 32'd2);
        cyc(0, 4'b0100, 1, 1, 4'b0000, 1);
        cyc(0, 4'b0100, 0, 1, 4'b0000, 1);
        cyc(0, 4'b0100, 0, 1, 4'b0000, 1);
        cyc(0, 4'b0100, 1, 0, 4'b0100, 1);
        cyc(0, 4'b0100, 0, 0, 4'b0100, 1);
        cyc(0, 4'b0100, 0, 0, 4'b0100, 1);
        cyc(0, 4'b0100, 0, 0, 4'b0100, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 1);

        // owner 1 drops after 2 beats; pointer moves to 2 so requester 2 beats requester 0
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
        cyc(0, 4'b0110, 0, 0, 4'b0010, 0);
        cyc(0, 4'b0110, 0, 0, 4'b0010, 1);
        cyc(0, 4'b0101, 0, 0, 4'b0000, 1);
        cyc(0, 4'b0101, 0, 0, 4'b0100, 0);
        cyc(0, 4'b0101, 0, 0, 4'b0100, 1);
        chk("owner_drop", 32'(owner_id), 32'd2);
        cyc(0, 4'b0001, 0, 0, 4'b0000, 1);
        cyc(0, 4'b0001, 0, 0, 4'b0001, 0);
        cyc(0, 4'b0001, 0, 0, 4'b0001, 1);

        // reset mid-burst while the last accepted beat is being written
        cyc(1, 4'b0001, 0, 0, 4'b0000, 1);
        cyc(0, 4'b1111, 0, 0, 4'b0001, 0);
`ifdef FIFO_ARB_STATS_EN
        chk("beat_count_rst", 32'(|beat_count), 32'd0);
        chk("stall_cycles_rst", 32'(stall_cycles), 32'd0);
`endif
        cyc(0, 4'b0000, 0, 0, 4'b0000, 1);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
